button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Front end for the three panel buttons (reset, start, skip); sits directly upstream of the workout FSM.
//   Per channel: 2-FF synchroniser, polarity normalisation, counter debounce, single-cycle press pulse.
//   Also produces a long-press pulse on the reset channel, which the FSM uses as "abort to IDLE".
//   The FSM consumes only these clean pulses, never raw pins.
// PARAMETERS
//   CLK_HZ          40_000_000  input clock frequency
//   DEBOUNCE_MS     10          required stable time before a level change is accepted
//   LONG_MS         1000        hold time for long_reset_pulse
//   SIM_SPEEDUP     1'b0        1: DEB_CYCLES=4, LONG_CYCLES=64 (overrides the ms values)
//   BTN_ACTIVE_LOW  1'b1        1: raw pin 0 = pressed
// PORTS
//   clk_40MHz         in   1  system clock, single domain
//   rst_n             in   1  asynchronous active-low reset
//   btn_reset_raw     in   1  raw pin, asynchronous to clk
//   btn_start_raw     in   1  raw pin, asynchronous to clk
//   btn_skip_raw      in   1  raw pin, asynchronous to clk
//   reset_pulse       out  1  1-cycle pulse on accepted press of the reset button
//   start_pulse       out  1  1-cycle pulse on accepted press of the start button
//   skip_pulse        out  1  1-cycle pulse on accepted press of the skip button
//   long_reset_pulse  out  1  1-cycle pulse once reset has been held LONG_CYCLES
//   btn_level         out  3  debounced pressed levels {skip,start,reset}, 1 = pressed
// BEHAVIOUR
//   Reset (async, rst_n=0): sync FFs=released, stable=0, counters=0, armed=0, all outputs 0.
//   Sync: 2 FFs per pin, then XOR with BTN_ACTIVE_LOW, giving s (1 = pressed).
//   Debounce: cnt increments while s != stable, clears on any cycle s == stable.
//     When cnt reaches DEB_CYCLES-1 and s != stable: stable <= s, cnt <= 0.
//     A glitch shorter than DEB_CYCLES cycles never changes stable.
//   Arming: armed <= 1 when stable == 0. A button held through reset gives no pulse until released and re-pressed.
//   Press pulse: raw_pulse = stable rising edge AND armed; registered output.
//     Latency from pin edge to pulse = 2 + DEB_CYCLES + 1 cycles (SIM: 7).
//   Release: no pulse. Holding a button never produces a second press pulse.
//   Priority in the same cycle (evaluated on raw_pulse):
//     reset > start > skip; lower-priority pulses are dropped, not deferred.
//     start_pulse and skip_pulse are forced 0 while btn_level[0] (reset) = 1.
//   Long press: hold_cnt counts while stable reset = 1 && armed; it is cleared when stable reset = 0.
//     When hold_cnt == LONG_CYCLES-1: long_reset_pulse for 1 cycle.
//     The counter then saturates: one pulse per hold.
//   Widths: DEB_CYCLES = SIM ? 4 : CLK_HZ/1000*DEBOUNCE_MS.
//     LONG_CYCLES = SIM ? 64 : CLK_HZ/1000*LONG_MS.
//     Counters are $clog2(N+1) bits, no wrap.
//   btn_level = registered stable bits, same timing as the pulses' source.
// STRUCTURE
//   fitness_pkg: BTN_RESET=0, BTN_START=1, BTN_SKIP=2 index constants.
//   fitness_pkg: function cycles_from_ms(clk_hz, ms); SIM debounce and long counts.
//   Sub-module btn_debounce_ch (sync + debounce + arm + rise detect), instantiated 3 times.
//   The top level holds the priority/masking logic and the long-press counter.
// TESTING (SIM_SPEEDUP=1, BTN_ACTIVE_LOW=1)
//   1. Power-on: pins high, rst_n low for 5 cycles -> all outputs 0.
//      Then 100 idle cycles -> no pulse, btn_level=000.
//   2. start_raw low for 10 cycles -> exactly one start_pulse, 7 cycles after the falling edge.
//      No pulse on release.
//   3. skip_raw low for 3 cycles -> no skip_pulse, btn_level[2] stays 0.
//      Bouncing 1-cycle toggles for 20 cycles, then low -> exactly one pulse.
//   4. start_raw and skip_raw fall on the same cycle -> start_pulse only, skip_pulse never asserts.
//      Skip pressed while reset is held -> no skip_pulse.
//   5. reset_raw held 100 cycles -> one reset_pulse, then one long_reset_pulse 64 cycles after btn_level[0] rose.
//      No further pulses until the button is released.
//   6. start_raw held low across rst_n assert/deassert -> no start_pulse.
//      Release, then re-press -> one start_pulse.

Source files
------------

// File: rtl/fitness_pkg.sv
// Shared constants for the panel-button front end.
//   BTN_*            bit index of each button in btn_level and internal vectors
//   SIM_*_CYCLES     short debounce / long-press counts used for fast simulation
//   cycles_from_ms   converts a millisecond interval to clock cycles
package fitness_pkg;

  localparam int unsigned BTN_RESET = 0;
  localparam int unsigned BTN_START = 1;
  localparam int unsigned BTN_SKIP  = 2;
  localparam int unsigned NUM_BTN   = 3;

  localparam int unsigned SIM_DEB_CYCLES  = 4;
  localparam int unsigned SIM_LONG_CYCLES = 64;

  function automatic int unsigned cycles_from_ms(input int unsigned clk_hz,
                                                 input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, polarity normalisation, counter
// debounce, press arming and rising-edge detect of the debounced level.
//   clk, rst_n  clock and asynchronous active-low reset
//   raw         raw pin, asynchronous to clk
//   level       debounced pressed level (1 = pressed)
//   rise        high for the one cycle after level rises, only when armed
module btn_debounce_ch #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned          CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [1:0]       valid_q;
  logic             s;
  logic             stable_q, stable_d, stable_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  assign s = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // The sync FFs come out of reset holding "released", so a released
    // sample only counts once a real pin value has reached sync2. This
    // keeps a button held through reset disarmed until it is let go.
    armed_d = armed_q | (valid_q[1] & ~stable_q & ~s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= ACTIVE_LOW;
      sync2_q       <= ACTIVE_LOW;
      valid_q       <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      valid_q       <= {valid_q[0], 1'b1};
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
    end
  end

  assign level = stable_q;
  assign rise  = stable_q & ~stable_prev_q & armed_q;

endmodule

// File: rtl/button_conditioner.sv
// Front end for the reset/start/skip panel buttons feeding the workout FSM.
// Produces clean single-cycle press pulses with fixed priority, a long-press
// pulse on the reset button, and the debounced button levels.
//   clk_40MHz, rst_n                  clock, asynchronous active-low reset
//   btn_{reset,start,skip}_raw        raw pins, asynchronous to the clock
//   {reset,start,skip}_pulse          1-cycle pulse per accepted press
//   long_reset_pulse                  1-cycle pulse once reset is held long
//   btn_level                         debounced levels {skip,start,reset}
module button_conditioner
  import fitness_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 40_000_000,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned LONG_MS        = 1000,
  parameter bit          SIM_SPEEDUP    = 1'b0,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_40MHz,
  input  logic       rst_n,
  input  logic       btn_reset_raw,
  input  logic       btn_start_raw,
  input  logic       btn_skip_raw,
  output logic       reset_pulse,
  output logic       start_pulse,
  output logic       skip_pulse,
  output logic       long_reset_pulse,
  output logic [2:0] btn_level
);

  localparam int unsigned DEB_CYCLES  = SIM_SPEEDUP ? SIM_DEB_CYCLES :
                                        cycles_from_ms(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES = SIM_SPEEDUP ? SIM_LONG_CYCLES :
                                        cycles_from_ms(CLK_HZ, LONG_MS);
  localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic [NUM_BTN-1:0] raw_pins, level, rise;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               hold_run;
  logic               reset_d, start_d, skip_d, long_d;

  assign raw_pins[BTN_RESET] = btn_reset_raw;
  assign raw_pins[BTN_START] = btn_start_raw;
  assign raw_pins[BTN_SKIP]  = btn_skip_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_ch (
      .clk   (clk_40MHz),
      .rst_n (rst_n),
      .raw   (raw_pins[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  always_comb begin
    // Lower-priority presses in the same cycle are dropped; start and skip
    // are ignored entirely while reset is held down.
    reset_d = rise[BTN_RESET];
    start_d = rise[BTN_START] & ~rise[BTN_RESET] & ~level[BTN_RESET];
    skip_d  = rise[BTN_SKIP] & ~rise[BTN_START] & ~rise[BTN_RESET] &
              ~level[BTN_RESET];

    // Arming cannot change while the level is high, so "held and armed" is
    // the same as "this hold began with an armed rise": start counting on
    // that rise and keep going while the counter is non-zero.
    hold_d   = '0;
    long_d   = 1'b0;
    hold_run = rise[BTN_RESET] | (hold_q != '0);
    if (level[BTN_RESET] && hold_run) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      long_d = (hold_q == HOLD_LAST);
    end
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      hold_q           <= '0;
      reset_pulse      <= 1'b0;
      start_pulse      <= 1'b0;
      skip_pulse       <= 1'b0;
      long_reset_pulse <= 1'b0;
    end else begin
      hold_q           <= hold_d;
      reset_pulse      <= reset_d;
      start_pulse      <= start_d;
      skip_pulse       <= skip_d;
      long_reset_pulse <= long_d;
    end
  end

  assign btn_level = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (SIM_SPEEDUP=1, active-low pins).
// A history-based reference model predicts every output on every cycle;
// directed scenarios add counts and latency checks on top.
module tb_button_conditioner;

  localparam int MaxE = 4095;

  logic       clk_40MHz = 1'b0;
  logic       rst_n;
  logic       btn_reset_raw, btn_start_raw, btn_skip_raw;
  logic       reset_pulse, start_pulse, skip_pulse, long_reset_pulse;
  logic [2:0] btn_level;

  button_conditioner #(
    .CLK_HZ         (40_000_000),
    .DEBOUNCE_MS    (10),
    .LONG_MS        (1000),
    .SIM_SPEEDUP    (1'b1),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_40MHz        (clk_40MHz),
    .rst_n            (rst_n),
    .btn_reset_raw    (btn_reset_raw),
    .btn_start_raw    (btn_start_raw),
    .btn_skip_raw     (btn_skip_raw),
    .reset_pulse      (reset_pulse),
    .start_pulse      (start_pulse),
    .skip_pulse       (skip_pulse),
    .long_reset_pulse (long_reset_pulse),
    .btn_level        (btn_level)
  );

  always #5 clk_40MHz = ~clk_40MHz;

  int n_checks = 0;
  int n_fail   = 0;

  // Model history, indexed by clock edges since reset was released.
  int e;
  bit pr  [3][MaxE+1];  // pressed value sampled at each edge
  bit lvl [3][MaxE+1];  // expected debounced level after each edge
  bit arm [3][MaxE+1];  // a genuine release has been seen by this edge

  logic [6:0] exp_vec, obs_vec;
  int cnt_rst, cnt_start, cnt_skip, cnt_long;
  int start_e, lvl0_rise_e, long_e, fall_e;
  bit lvl0_prev, lvl2_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, e);
    end
  endtask

  // Synchronised pressed value seen by the debouncer before edge k.
  function automatic bit s_at(int c, int k);
    return (k >= 3) ? pr[c][k-2] : 1'b0;
  endfunction

  task automatic clr_counts();
    cnt_rst = 0; cnt_start = 0; cnt_skip = 0; cnt_long = 0;
    start_e = -1; lvl0_rise_e = -1; long_e = -1; lvl2_seen = 1'b0;
  endtask

  task automatic tick();
    bit raw_p [3];
    bit v, win, long_x;
    @(posedge clk_40MHz);
    if (!rst_n) begin
      e = 0;
      exp_vec = '0;
      for (int c = 0; c < 3; c++) begin
        lvl[c][0] = 1'b0;
        arm[c][0] = 1'b0;
      end
    end else begin
      if (e >= MaxE) begin
        $display("FAIL model_history: edge %0d exceeds %0d", e, MaxE);
        $fatal(1, "model history overflow");
      end
      e++;
      pr[0][e] = ~btn_reset_raw;
      pr[1][e] = ~btn_start_raw;
      pr[2][e] = ~btn_skip_raw;
      for (int c = 0; c < 3; c++) begin
        // Level follows the input once it has differed for 4 straight cycles.
        lvl[c][e] = lvl[c][e-1];
        if (e >= 4) begin
          v = s_at(c, e);
          win = 1'b1;
          for (int k = e - 3; k <= e; k++) if (s_at(c, k) != v) win = 1'b0;
          if (win && v != lvl[c][e-1]) lvl[c][e] = v;
        end
        arm[c][e] = arm[c][e-1] | ((e >= 3) && !lvl[c][e-1] && !s_at(c, e));
        raw_p[c] = (e >= 2) && lvl[c][e-1] && !lvl[c][e-2] && arm[c][e-1];
      end
      // Long press: reset level high for exactly the last 64 edges after an armed rise.
      long_x = 1'b0;
      if (e >= 65) begin
        long_x = arm[0][e-64] && !lvl[0][e-65];
        for (int k = e - 64; k <= e - 1; k++) if (!lvl[0][k]) long_x = 1'b0;
      end
      exp_vec = {long_x,
                 raw_p[2] & ~raw_p[1] & ~raw_p[0] & ~lvl[0][e-1],
                 raw_p[1] & ~raw_p[0] & ~lvl[0][e-1],
                 raw_p[0],
                 lvl[2][e], lvl[1][e], lvl[0][e]};
    end
    #1;
    obs_vec = {long_reset_pulse, skip_pulse, start_pulse, reset_pulse, btn_level};
    chk("cycle", 32'(obs_vec), 32'(exp_vec));
    if (reset_pulse) cnt_rst++;
    if (start_pulse) begin cnt_start++; start_e = e; end
    if (skip_pulse) cnt_skip++;
    if (long_reset_pulse) begin cnt_long++; long_e = e; end
    if (btn_level[0] && !lvl0_prev) lvl0_rise_e = e;
    lvl0_prev = btn_level[0];
    if (btn_level[2]) lvl2_seen = 1'b1;
  endtask

  int run [3];

  initial begin
    rst_n = 1'b0;
    btn_reset_raw = 1'b1; btn_start_raw = 1'b1; btn_skip_raw = 1'b1;
    e = 0; lvl0_prev = 1'b0;
    clr_counts();

    // 1. Power-on reset, then idle.
    repeat (5) tick();
    chk("reset_outputs", 32'(obs_vec), 32'd0);
    rst_n = 1'b1;
    repeat (100) tick();
    chk("idle_pulses", 32'(cnt_rst + cnt_start + cnt_skip + cnt_long), 32'd0);
    chk("idle_level", 32'(btn_level), 32'd0);

    // 2. Single start press: one pulse, 7 cycles after the pin edge.
    clr_counts();
    fall_e = e;
    btn_start_raw = 1'b0;
    repeat (10) tick();
    btn_start_raw = 1'b1;
    repeat (20) tick();
    chk("start_count", 32'(cnt_start), 32'd1);
    chk("start_latency", 32'(start_e - fall_e), 32'd7);
    chk("start_released", 32'(btn_level[1]), 32'd0);

    // 3. Short glitch on skip, then a bouncing press.
    clr_counts();
    btn_skip_raw = 1'b0;
    repeat (3) tick();
    btn_skip_raw = 1'b1;
    repeat (10) tick();
    chk("skip_glitch_count", 32'(cnt_skip), 32'd0);
    chk("skip_glitch_level", 32'(lvl2_seen), 32'd0);
    for (int i = 0; i < 20; i++) begin
      btn_skip_raw = ~btn_skip_raw;
      tick();
    end
    btn_skip_raw = 1'b0;
    repeat (12) tick();
    btn_skip_raw = 1'b1;
    repeat (15) tick();
    chk("skip_bounce_count", 32'(cnt_skip), 32'd1);

    // 4. Simultaneous start+skip, then skip while reset is held.
    clr_counts();
    btn_start_raw = 1'b0; btn_skip_raw = 1'b0;
    repeat (12) tick();
    btn_start_raw = 1'b1; btn_skip_raw = 1'b1;
    repeat (15) tick();
    chk("prio_start_count", 32'(cnt_start), 32'd1);
    chk("prio_skip_count", 32'(cnt_skip), 32'd0);
    clr_counts();
    btn_reset_raw = 1'b0;
    repeat (12) tick();
    btn_skip_raw = 1'b0;
    repeat (12) tick();
    btn_skip_raw = 1'b1;
    repeat (12) tick();
    btn_reset_raw = 1'b1;
    repeat (15) tick();
    chk("mask_skip_count", 32'(cnt_skip), 32'd0);
    chk("mask_reset_count", 32'(cnt_rst), 32'd1);

    // 5. Long hold of reset.
    clr_counts();
    btn_reset_raw = 1'b0;
    repeat (100) tick();
    chk("long_reset_count", 32'(cnt_rst), 32'd1);
    chk("long_count", 32'(cnt_long), 32'd1);
    chk("long_delay", 32'(long_e - lvl0_rise_e), 32'd64);
    repeat (100) tick();
    chk("long_no_repeat", 32'(cnt_long + cnt_rst), 32'd2);
    btn_reset_raw = 1'b1;
    repeat (15) tick();

    // 6. Start held across reset gives no pulse until released and re-pressed.
    clr_counts();
    btn_start_raw = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("held_reset_start", 32'(cnt_start), 32'd0);
    chk("held_reset_level", 32'(btn_level[1]), 32'd1);
    btn_start_raw = 1'b1;
    repeat (15) tick();
    btn_start_raw = 1'b0;
    repeat (12) tick();
    btn_start_raw = 1'b1;
    repeat (15) tick();
    chk("repress_start", 32'(cnt_start), 32'd1);

    // Random pin activity against the model.
    clr_counts();
    for (int c = 0; c < 3; c++) run[c] = $urandom_range(1, 14);
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (run[c] == 0) begin
          case (c)
            0: btn_reset_raw = ~btn_reset_raw;
            1: btn_start_raw = ~btn_start_raw;
            default: btn_skip_raw = ~btn_skip_raw;
          endcase
          run[c] = (c == 0 && $urandom_range(0, 5) == 0) ? $urandom_range(60, 90)
                                                          : $urandom_range(1, 14);
        end else begin
          run[c]--;
        end
      end
      tick();
    end
    btn_reset_raw = 1'b1; btn_start_raw = 1'b1; btn_skip_raw = 1'b1;
    repeat (80) tick();
    chk("final_level", 32'(btn_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
